// File: rtl/zap_fifo_pkg.sv
// rtl/zap_fifo_pkg.sv - shared sizing helpers and control/lane decode functions for zap_fifo_mw
package zap_fifo_pkg;

  localparam int MAX_LANES = 4;
  localparam int MAX_CTL   = 32;
  localparam int LCW       = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index of the highest-priority (lowest-numbered) request; MAX_CTL when none.
  function automatic int ctl_first(input logic [MAX_CTL-1:0] req);
    int idx;
    idx = MAX_CTL;
    for (int i = MAX_CTL - 1; i >= 0; i--) begin
      if (req[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic [LCW-1:0] lane_popcount(input logic [MAX_LANES-1:0] v);
    logic [LCW-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {{(LCW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Legal lane masks are of the form 2^n-1: filled from lane 0 with no gaps.
  function automatic logic lanes_contiguous(input logic [MAX_LANES-1:0] v);
    return (v & (v + MAX_LANES'(1))) == '0;
  endfunction

endpackage

// File: rtl/zap_mw_sync_fifo.sv
// rtl/zap_mw_sync_fifo.sv - multi-write single-read storage with pointers, occupancy and full flags
module zap_mw_sync_fifo
  import zap_fifo_pkg::*;
#(
  parameter int WDT       = 32,
  parameter int DEPTH     = 16,
  parameter int WR_LANES  = 2,
  parameter int AFULL_THR = 12,
  parameter int AW        = clog2(DEPTH),
  parameter int CW        = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [LCW-1:0]          wr_cnt,
  input  logic [WR_LANES*WDT-1:0] wr_data,
  input  logic                    pop,
  output logic [WDT-1:0]          rd_data,
  output logic [CW-1:0]           count,
  output logic                    empty,
  output logic                    full,
  output logic                    afull
);

  logic [DEPTH-1:0][WDT-1:0] mem_q, mem_d;
  logic [AW-1:0]             wptr_q, wptr_d;
  logic [AW-1:0]             rptr_q, rptr_d;
  logic [CW-1:0]             count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < WR_LANES; k++) begin
        if (LCW'(k) < wr_cnt) mem_d[wptr_q + AW'(k)] = wr_data[k*WDT +: WDT];
      end
      wptr_d  = wptr_q + AW'(wr_cnt);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + CW'(wr_cnt) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Flags come only from the registered count so fetch throttling sees no input-to-output path.
  assign rd_data = mem_q[rptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q > CW'(DEPTH - WR_LANES));
  assign afull   = (count_q >= CW'(AFULL_THR));

endmodule

// File: rtl/zap_fifo_mw.sv
// rtl/zap_fifo_mw.sv - fetch-to-decode multi-lane FIFO stage with prioritised clear/stall control
module zap_fifo_mw
  import zap_fifo_pkg::*;
#(
  parameter int                 WDT       = 32,
  parameter int                 DEPTH     = 16,
  parameter int                 WR_LANES  = 2,
  parameter int                 NUM_CTL   = 7,
  parameter logic [NUM_CTL-1:0] CTL_CLEAR = 7'b1000101,
  parameter int                 AFULL_THR = 12
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [NUM_CTL-1:0]         i_ctl,
  input  logic                       i_write_inhibit,
  input  logic [WR_LANES-1:0]        i_valid,
  input  logic [WR_LANES*WDT-1:0]    i_instr,
  output logic                       o_full,
  output logic                       o_afull,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [WDT-1:0]             o_instr,
  output logic                       o_valid
);

  localparam int CW = clog2(DEPTH) + 1;

  logic                 rd_en, clear, contig, pop;
  logic                 fifo_empty, fifo_full, fifo_afull;
  logic [MAX_LANES-1:0] valid_ext;
  logic [LCW-1:0]       wr_cnt;
  logic [WDT-1:0]       head;
  logic [CW-1:0]        fifo_count;
  int                   ctl_idx;

  logic [WDT-1:0] instr_q, instr_d;
  logic           valid_q, valid_d;

  // A stall at higher priority wins over any lower clear: only the first set request counts.
  always_comb begin
    ctl_idx = ctl_first(MAX_CTL'(i_ctl));
    rd_en   = (ctl_idx == MAX_CTL);
    clear   = 1'b0;
    for (int k = 0; k < NUM_CTL; k++) begin
      if (ctl_idx == k) clear = CTL_CLEAR[k];
    end
  end

  assign valid_ext = MAX_LANES'(i_valid);
  assign contig    = lanes_contiguous(valid_ext);
  assign wr_cnt    = (!i_write_inhibit && !fifo_full && !clear && contig) ? lane_popcount(valid_ext) : '0;
  assign pop       = rd_en && !fifo_empty;

  zap_mw_sync_fifo #(
    .WDT       (WDT),
    .DEPTH     (DEPTH),
    .WR_LANES  (WR_LANES),
    .AFULL_THR (AFULL_THR)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .clear   (clear),
    .wr_cnt  (wr_cnt),
    .wr_data (i_instr),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .afull   (fifo_afull)
  );

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (rd_en) begin
      valid_d = !fifo_empty;
      if (!fifo_empty) instr_d = head;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign o_instr = instr_q;
  assign o_valid = valid_q;
  assign o_count = fifo_count;
  assign o_full  = fifo_full;
  assign o_afull = fifo_afull;

  a_lanes_contiguous : assert property (@(posedge i_clk) disable iff (!i_reset_n) contig);

endmodule

// File: tb/tb_zap_fifo_mw.sv
// tb/tb_zap_fifo_mw.sv - directed table-driven and sequence checks for zap_fifo_mw
module tb_zap_fifo_mw;

  localparam int WDT      = 32;
  localparam int DEPTH    = 16;
  localparam int WR_LANES = 2;
  localparam int NUM_CTL  = 7;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CTL-1:0]      ctl;
  logic                    inhibit;
  logic [WR_LANES-1:0]     vld;
  logic [WR_LANES*WDT-1:0] instr;
  logic                    o_full, o_afull, o_valid;
  logic [4:0]              o_count;
  logic [WDT-1:0]          o_instr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zap_fifo_mw #(
    .WDT       (WDT),
    .DEPTH     (DEPTH),
    .WR_LANES  (WR_LANES),
    .NUM_CTL   (NUM_CTL),
    .CTL_CLEAR (7'b1000101),
    .AFULL_THR (12)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_ctl           (ctl),
    .i_write_inhibit (inhibit),
    .i_valid         (vld),
    .i_instr         (instr),
    .o_full          (o_full),
    .o_afull         (o_afull),
    .o_count         (o_count),
    .o_instr         (o_instr),
    .o_valid         (o_valid)
  );

  typedef struct {
    logic [6:0]  ctl;
    logic        inh;
    logic [1:0]  vld;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [4:0]  e_count;
  } vec_t;

  vec_t tbl[16];
  logic [31:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] c, input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
    ctl     = c;
    inhibit = 1'b0;
    vld     = v;
    instr   = {d1, d0};
  endtask

  initial begin
    logic [31:0] exp_d;
    logic        stall, mfull, popped;
    logic [31:0] nxt;

    tbl[0]  = '{7'h00, 1'b0, 2'b11, 32'ha1, 32'hb2, 1'b0, 32'h00, 5'd2};
    tbl[1]  = '{7'h00, 1'b0, 2'b00, 32'h00, 32'h00, 1'b1, 32'ha1, 5'd1};
    tbl[2]  = '{7'h00, 1'b0, 2'b00, 32'h00, 32'h00, 1'b1, 32'hb2, 5'd0};
    tbl[3]  = '{7'h00, 1'b0, 2'b00, 32'h00, 32'h00, 1'b0, 32'hb2, 5'd0};
    tbl[4]  = '{7'h00, 1'b1, 2'b11, 32'hc3, 32'hd4, 1'b0, 32'hb2, 5'd0};
    tbl[5]  = '{7'h00, 1'b0, 2'b01, 32'he5, 32'h00, 1'b0, 32'hb2, 5'd1};
    tbl[6]  = '{7'h10, 1'b0, 2'b11, 32'hc3, 32'hd4, 1'b0, 32'hb2, 5'd3};
    tbl[7]  = '{7'h00, 1'b0, 2'b11, 32'hf6, 32'h17, 1'b1, 32'he5, 5'd4};
    tbl[8]  = '{7'h04, 1'b0, 2'b11, 32'h18, 32'h19, 1'b0, 32'he5, 5'd0};
    tbl[9]  = '{7'h00, 1'b0, 2'b01, 32'h1a, 32'h00, 1'b0, 32'he5, 5'd1};
    tbl[10] = '{7'h00, 1'b0, 2'b00, 32'h00, 32'h00, 1'b1, 32'h1a, 5'd0};
    tbl[11] = '{7'h00, 1'b0, 2'b11, 32'h1b, 32'h1c, 1'b0, 32'h1a, 5'd2};
    tbl[12] = '{7'h40, 1'b0, 2'b00, 32'h00, 32'h00, 1'b0, 32'h1a, 5'd0};
    tbl[13] = '{7'h08, 1'b0, 2'b11, 32'h1d, 32'h1e, 1'b0, 32'h1a, 5'd2};
    tbl[14] = '{7'h02, 1'b0, 2'b00, 32'h00, 32'h00, 1'b0, 32'h1a, 5'd2};
    tbl[15] = '{7'h00, 1'b0, 2'b00, 32'h00, 32'h00, 1'b1, 32'h1d, 5'd1};

    rst_n = 1'b0;
    drive(7'h00, 2'b00, 32'h0, 32'h0);
    cyc();
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_full",  32'(o_full), 32'd0);
    chk("rst_afull", 32'(o_afull), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ctl, tbl[i].vld, tbl[i].d0, tbl[i].d1);
      inhibit = tbl[i].inh;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_instr", i), o_instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_full", i),  32'(o_full), 32'd0);
    end

    drive(7'h01, 2'b00, 32'h0, 32'h0);
    cyc();
    chk("clr_count", 32'(o_count), 32'd0);
    chk("clr_valid", 32'(o_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      drive(7'h10, 2'b11, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i));
      cyc();
      chk($sformatf("fill%0d_count", i), 32'(o_count), 32'(2*(i+1)));
      chk($sformatf("fill%0d_afull", i), 32'(o_afull), 32'(2*(i+1) >= 12));
      chk($sformatf("fill%0d_full", i),  32'(o_full), 32'(i == 7));
    end
    drive(7'h10, 2'b11, 32'h200, 32'h201);
    cyc();
    chk("fill_drop_count", 32'(o_count), 32'd16);
    chk("fill_drop_full",  32'(o_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(7'h00, 2'b00, 32'h0, 32'h0);
      cyc();
      chk($sformatf("drain%0d_valid", i), 32'(o_valid), 32'd1);
      chk($sformatf("drain%0d_instr", i), o_instr, 32'h100 + 32'(i));
      chk($sformatf("drain%0d_count", i), 32'(o_count), 32'(15 - i));
      chk($sformatf("drain%0d_full", i),  32'(o_full), 32'((15 - i) >= 15));
      chk($sformatf("drain%0d_afull", i), 32'(o_afull), 32'((15 - i) >= 12));
    end
    cyc();
    chk("empty_valid", 32'(o_valid), 32'd0);
    chk("empty_instr", o_instr, 32'h10f);

    drive(7'h10, 2'b11, 32'h300, 32'h301); cyc();
    drive(7'h10, 2'b11, 32'h302, 32'h303); cyc();
    drive(7'h10, 2'b01, 32'h304, 32'h0);   cyc();
    chk("hold_setup_count", 32'(o_count), 32'd5);
    drive(7'h00, 2'b00, 32'h0, 32'h0); cyc();
    chk("hold_pop_instr", o_instr, 32'h300);
    drive(7'h10, 2'b01, 32'h305, 32'h0); cyc();
    chk("stall_hold_valid", 32'(o_valid), 32'd1);
    chk("stall_hold_count", 32'(o_count), 32'd5);
    for (int i = 0; i < 2; i++) begin
      drive(7'h06, 2'b00, 32'h0, 32'h0);
      cyc();
      chk("stall_over_clr_count", 32'(o_count), 32'd5);
      chk("stall_over_clr_valid", 32'(o_valid), 32'd1);
      chk("stall_over_clr_instr", o_instr, 32'h300);
    end
    drive(7'h03, 2'b00, 32'h0, 32'h0);
    cyc();
    chk("clr_over_stall_count", 32'(o_count), 32'd0);
    chk("clr_over_stall_valid", 32'(o_valid), 32'd0);
    chk("clr_over_stall_instr", o_instr, 32'h300);

    nxt = 32'h400;
    q.delete();
    for (int c = 0; c < 40; c++) begin
      stall = c[0];
      mfull = (DEPTH - q.size()) < 2;
      chk($sformatf("wrap%0d_full", c), 32'(o_full), 32'(mfull));
      drive(stall ? 7'h10 : 7'h00, 2'b11, nxt, nxt + 32'd1);
      popped = !stall && (q.size() > 0);
      exp_d  = popped ? q.pop_front() : 32'h0;
      if (!mfull) begin
        q.push_back(nxt);
        q.push_back(nxt + 32'd1);
      end
      nxt = nxt + 32'd2;
      cyc();
      if (popped) begin
        chk($sformatf("wrap%0d_valid", c), 32'(o_valid), 32'd1);
        chk($sformatf("wrap%0d_instr", c), o_instr, exp_d);
      end
      chk($sformatf("wrap%0d_count", c), 32'(o_count), 32'(q.size()));
    end
    for (int c = 0; c < 40; c++) begin
      if (q.size() == 0) break;
      drive(7'h00, 2'b00, 32'h0, 32'h0);
      exp_d = q.pop_front();
      cyc();
      chk($sformatf("wdrain%0d_valid", c), 32'(o_valid), 32'd1);
      chk($sformatf("wdrain%0d_instr", c), o_instr, exp_d);
    end
    chk("wdrain_count", 32'(o_count), 32'd0);

    drive(7'h10, 2'b11, 32'h500, 32'h501); cyc();
    drive(7'h10, 2'b11, 32'h502, 32'h503); cyc();
    drive(7'h10, 2'b11, 32'h504, 32'h505); cyc();
    drive(7'h10, 2'b01, 32'h506, 32'h0);   cyc();
    chk("prerst_count", 32'(o_count), 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(o_count), 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_instr", o_instr, 32'd0);
    chk("midrst_full",  32'(o_full), 32'd0);
    chk("midrst_afull", 32'(o_afull), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'h00, 2'b11, 32'h600, 32'h601);
    cyc();
    chk("postrst_w_count", 32'(o_count), 32'd2);
    chk("postrst_w_valid", 32'(o_valid), 32'd0);
    drive(7'h00, 2'b00, 32'h0, 32'h0);
    cyc();
    chk("postrst_r_valid", 32'(o_valid), 32'd1);
    chk("postrst_r_instr", o_instr, 32'h600);
    cyc();
    chk("postrst_r2_instr", o_instr, 32'h601);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zap_fifo_mw.md
# zap_fifo_mw

Multi-lane pipeline FIFO stage sitting between fetch and decode: accepts up to `WR_LANES` instructions per cycle, delivers one instruction per cycle through a registered output, and derives its clear/hold decision from a parametrised priority-ordered vector of pipeline control requests. It generalises the single-lane fetch FIFO stage: configurable write width, an ordered control vector instead of fixed stall/clear pins, and occupancy/almost-full reporting for fetch throttling.

## Interface
- `WDT`, 32: payload width per lane.
- `DEPTH`, 16: entries; power of two, ≥ 2·`WR_LANES`.
- `WR_LANES`, 2: write lanes per cycle, 1..4.
- `NUM_CTL`, 7: number of pipeline control requests.
- `CTL_CLEAR`, 7'b1000101: bit k=1 means request k is a clear, 0 a stall.
- `AFULL_THR`, 12: occupancy at or above which `o_afull` asserts.
- `i_clk` in 1: clock.
- `i_reset_n` in 1: asynchronous active-low reset.
- `i_ctl` in `NUM_CTL`: control requests, bit 0 highest priority.
- `i_write_inhibit` in 1: drop all writes this cycle.
- `i_valid` in `WR_LANES`: per-lane write valid; must be contiguous from lane 0.
- `i_instr` in `WR_LANES*WDT`: lane k at bits [k*WDT +: WDT].
- `o_full` out 1: free entries < `WR_LANES`.
- `o_afull` out 1: occupancy ≥ `AFULL_THR`.
- `o_count` out `$clog2(DEPTH)+1`: registered occupancy.
- `o_instr` out `WDT`: registered output payload.
- `o_valid` out 1: `o_instr` valid.

## Operation
- Control decode: find lowest-index set bit j of `i_ctl`. None → `rd_en`=1, `clear`=0. Else `rd_en`=0, `clear`=`CTL_CLEAR[j]`. A stall at higher priority masks any lower clear.
- Write: `wr_cnt` = popcount(`i_valid`) when `!i_write_inhibit && !o_full && !clear`, else 0. Lanes written in order at `wptr`, `wptr+1`, …; pointers wrap modulo `DEPTH`. All-or-nothing: no partial lane acceptance.
- Non-contiguous `i_valid` (e.g. 2'b10) is illegal; assertion fires, write dropped.
- Read: when `rd_en` and count>0, pop head; output register loads `o_instr`←head, `o_valid`←1. When `rd_en` and empty, `o_valid`←0, `o_instr` held. When `!rd_en && !clear`, output register and FIFO hold.
- Clear: pointers and count reset to 0, `o_valid`←0 on next edge; same-cycle writes discarded; `o_instr` held.
- Count update: `count + wr_cnt - pop`; never exceeds `DEPTH` (guaranteed by `o_full`).
- `o_full`, `o_afull` derive from registered count only; no combinational path from `i_ctl`/`i_valid`.

## Timing
- Reset (async assert, sync-deasserted externally): `o_valid`=0, `o_instr`=0, `o_count`=0, `o_full`=0, `o_afull`=0, pointers 0.
- Latency: write at edge t → `o_valid` at edge t+1 earliest (2-cycle input-to-output, one storage + one output register).
- Simultaneous write and pop in same cycle: both take effect; full-state write still refused since `o_full` uses pre-edge count.
- Clear and write same cycle: clear wins. Stall and write: write accepted.
- Reset asserted mid-burst: all state cleared immediately, no output glitch beyond reset values.

## Structure
- `zap_fifo_pkg`: lane-count/pointer-width localparams helper function (`clog2`), control-priority encoder function.
- One sub-module: `zap_mw_sync_fifo` (multi-write, single-read storage, pointers, count, full/afull); top holds control decode and output register.

## Test plan
- Reset then write 2 lanes {A,B} at cycle 1, no ctl → `o_valid` with A at cycle 2, B at cycle 3, `o_count` 2→1→0.
- Fill with 2-lane writes under ctl stall (bit 4) → after 8 cycles `o_count`=16, `o_full`=1, `o_afull`=1 from count 12; further writes dropped.
- `i_ctl`=7'b0000011 (bit0 clear, bit1 stall) with 5 entries → count 0, `o_valid`=0 next edge.
- `i_ctl`=7'b0000110 (bit1 stall over bit2 clear) → FIFO and output hold, count unchanged.
- Pointer wrap: 40 cycles continuous 2-in/1-out with stall every other cycle → output order exactly matches input order, no loss.
- Assert `i_reset_n`=0 mid-stream with count 7 → all outputs zero immediately; first post-reset write reappears after 2 cycles.
